// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared types and helpers for the data-memory bridge
package riscv_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE  = 2'd0,
    SZ_HALF  = 2'd1,
    SZ_WORD  = 2'd2,
    SZ_DWORD = 2'd3
  } mem_size_e;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_REQ      = 3'd1,
    ST_WAIT_RSP = 3'd2,
    ST_DONE     = 3'd3,
    ST_ERR      = 3'd4
  } state_e;

  // Natural alignment: the low address bits below the access size must be zero.
  function automatic logic is_aligned(input mem_size_e sz, input logic [2:0] a);
    case (sz)
      SZ_BYTE: is_aligned = 1'b1;
      SZ_HALF: is_aligned = (a[0] == 1'b0);
      SZ_WORD: is_aligned = (a[1:0] == 2'b00);
      default: is_aligned = (a == 3'b000);
    endcase
  endfunction

  // Byte enables for the widest (8-byte) bus; narrower buses take the low bits.
  function automatic logic [7:0] byte_en(input mem_size_e sz, input logic [2:0] off);
    case (sz)
      SZ_BYTE: byte_en = 8'h01 << off;
      SZ_HALF: byte_en = 8'h03 << off;
      SZ_WORD: byte_en = 8'h0F << off;
      default: byte_en = 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/riscv_load_align.sv
// rtl/riscv_load_align.sv - load lane select and sign/zero extension
module riscv_load_align
  import riscv_mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [2:0]      offset_i,
  input  mem_size_e       size_i,
  input  logic            unsigned_i,
  output logic [XLEN-1:0] data_o
);

  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] mask;
  logic            sbit;

  // Shift the addressed lane down to bit 0, keep its width and fill above it.
  always_comb begin
    lane = rdata_i >> {offset_i, 3'b000};
    case (size_i)
      SZ_BYTE: begin mask = XLEN'(8'hFF);         sbit = lane[7];  end
      SZ_HALF: begin mask = XLEN'(16'hFFFF);      sbit = lane[15]; end
      SZ_WORD: begin mask = XLEN'(32'hFFFF_FFFF); sbit = lane[31]; end
      default: begin mask = '1;                   sbit = 1'b0;     end
    endcase
    data_o = (lane & mask) | ({XLEN{sbit & ~unsigned_i}} & ~mask);
  end

endmodule

// File: rtl/riscv_dmem_bridge.sv
// rtl/riscv_dmem_bridge.sv - core load/store to valid/ready memory request bridge
module riscv_dmem_bridge
  import riscv_mem_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       data_addr,
  input  logic [XLEN-1:0]   data_wr_data,
  input  logic              mem_rd_en,
  input  logic              mem_wr_en,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  output logic [XLEN-1:0]   data_rd_data,
  output logic              stall,
  output logic              err,
  output logic              req_valid,
  input  logic              req_ready,
  output logic              req_we,
  output logic [31:0]       req_addr,
  output logic [XLEN-1:0]   req_wdata,
  output logic [XLEN/8-1:0] req_be,
  input  logic              rsp_valid,
  input  logic [XLEN-1:0]   rsp_rdata
);

  localparam int          NB        = XLEN / 8;
  localparam int          OW        = $clog2(NB);
  localparam logic [15:0] TMAX      = 16'(TIMEOUT - 1);
  localparam logic [31:0] ADDR_MASK = ~32'(NB - 1);

  state_e            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       addr_q, addr_d;
  mem_size_e         size_q, size_d;
  logic              uns_q, uns_d;
  logic              we_q, we_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]     be_q, be_d;
  logic [XLEN-1:0]   rd_q, rd_d;

  mem_size_e         size_in;
  logic [2:0]        off_in;
  logic [2:0]        off_q;
  logic [7:0]        be_full;
  logic              access_bad;
  logic [XLEN-1:0]   wdata_rep;
  logic [XLEN-1:0]   load_data;

  assign size_in    = mem_size_e'(mem_size);
  assign off_in     = 3'(data_addr[OW-1:0]);
  assign off_q      = 3'(addr_q[OW-1:0]);
  assign be_full    = byte_en(size_in, off_in);
  assign access_bad = (mem_rd_en & mem_wr_en) | ~is_aligned(size_in, off_in) |
                      ((XLEN == 32) && (size_in == SZ_DWORD));

  // Replicate the store operand across every lane of its size.
  always_comb begin
    case (size_in)
      SZ_BYTE: wdata_rep = {NB{data_wr_data[7:0]}};
      SZ_HALF: wdata_rep = {(NB/2){data_wr_data[15:0]}};
      SZ_WORD: wdata_rep = {(NB/4){data_wr_data[31:0]}};
      default: wdata_rep = data_wr_data;
    endcase
  end

  riscv_load_align #(.XLEN(XLEN)) u_load_align (
    .rdata_i    (rsp_rdata),
    .offset_i   (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (load_data)
  );

  // Access FSM: accept in IDLE, handshake in REQ, collect in WAIT_RSP, report in DONE/ERR.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    size_d  = size_q;
    uns_d   = uns_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rd_d    = rd_q;
    stall   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (mem_rd_en | mem_wr_en) begin
          stall = 1'b1;
          if (access_bad) begin
            state_d = ST_ERR;
            rd_d    = '0;
          end else begin
            state_d = ST_REQ;
            cnt_d   = '0;
            addr_d  = data_addr;
            size_d  = size_in;
            uns_d   = mem_unsigned;
            we_d    = mem_wr_en;
            wdata_d = wdata_rep;
            be_d    = be_full[NB-1:0];
          end
        end
      end
      ST_REQ: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (req_ready) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT_RSP;
            cnt_d   = '0;
          end
        end else if (cnt_q == TMAX) begin
          state_d = ST_ERR;
          rd_d    = '0;
        end
      end
      ST_WAIT_RSP: begin
        stall = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (rsp_valid) begin
          state_d = ST_DONE;
          rd_d    = load_data;
        end else if (cnt_q == TMAX) begin
          state_d = ST_ERR;
          rd_d    = '0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and request registers; reset drops any in-flight access immediately.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rd_q    <= rd_d;
    end
  end

  assign req_valid    = (state_q == ST_REQ);
  assign err          = (state_q == ST_ERR);
  assign req_we       = we_q;
  assign req_addr     = addr_q & ADDR_MASK;
  assign req_wdata    = wdata_q;
  assign req_be       = be_q;
  assign data_rd_data = rd_q;

endmodule

// File: doc/riscv_dmem_bridge.md
RISCV_DMEM_BRIDGE -- requirements
Module: riscv_dmem_bridge

Interface
REQ-001 Parameter XLEN, 32, core/memory data width; legal values 32 or 64.
REQ-002 Parameter TIMEOUT, 64, max cycles in REQ or WAIT_RSP before error; legal range 2..65535.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-low reset: rst=0 at a rising clk edge resets the block.
REQ-005 data_addr  in  32  core byte address.
REQ-006 data_wr_data  in  XLEN  core store data, right-aligned.
REQ-007 mem_rd_en / mem_wr_en  in  1 each  core load / store request.
REQ-008 mem_size  in  2  access size: 0 byte, 1 half, 2 word, 3 dword (XLEN=64 only).
REQ-009 mem_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-010 data_rd_data  out  XLEN  formatted load result.
REQ-011 stall  out  1  core holds all request inputs while 1.
REQ-012 err  out  1  one-cycle pulse on a failed access.
REQ-013 req_valid / req_ready  out / in  1 each  memory request handshake.
REQ-014 req_we  out  1; req_addr  out  32 (XLEN/8-aligned); req_wdata  out  XLEN; req_be  out  XLEN/8.
REQ-015 rsp_valid  in  1; rsp_rdata  in  XLEN  read response, one beat per read.

Function
REQ-016 The FSM SHALL have states IDLE, REQ, WAIT_RSP, DONE, ERR.
REQ-017 In IDLE, an aligned access (exactly one enable high) SHALL combinationally assert stall, register address, size, sign mode and lane-shifted write data, and go to REQ.
REQ-018 In IDLE, a misaligned access, mem_size=3 with XLEN=32, or both enables high SHALL go to ERR without a memory request; stall SHALL be 1 in that cycle.
REQ-019 Alignment rule: half requires addr[0]=0, word requires addr[1:0]=0, dword requires addr[2:0]=0.
REQ-020 In REQ, req_valid SHALL be 1 and request fields stable until req_ready=1; on the handshake a write goes to DONE and a read goes to WAIT_RSP.
REQ-021 In WAIT_RSP, rsp_valid SHALL capture the formatted rsp_rdata into data_rd_data and go to DONE; rsp_valid in any other state SHALL be ignored.
REQ-022 In DONE, stall SHALL be 0 and data_rd_data SHALL be valid for that cycle; next state is IDLE.
REQ-023 In ERR, stall=0, err=1 and data_rd_data=0; next state is IDLE.
REQ-024 A wait counter SHALL clear on entering REQ or WAIT_RSP, increment each cycle, and force ERR when it reaches TIMEOUT-1 without handshake; req_valid SHALL drop in ERR.
REQ-025 req_be: byte = 1 << offset, half = 3 << offset, word = 0xF << offset, dword = all ones, with offset = addr mod (XLEN/8).
REQ-026 req_wdata SHALL replicate the low byte/half/word of data_wr_data across all lanes of that size.
REQ-027 Load data SHALL select the addressed lane and sign- or zero-extend it to XLEN.
REQ-028 Minimum access latency: write 2 cycles of stall (IDLE, REQ) with zero-wait memory; read 3 (IDLE, REQ, WAIT_RSP) with rsp_valid on the cycle after the handshake.

Reset
REQ-029 On reset: state=IDLE, counter=0; req_valid, req_we, err, stall = 0; req_addr, req_wdata, req_be, data_rd_data = 0.
REQ-030 Reset SHALL abort any state, including a pending handshake, in one edge; a later stale rsp_valid SHALL be ignored.

Structure
REQ-031 Shared package riscv_mem_pkg SHALL hold the mem_size enum, the FSM state enum and functions for byte-enable and alignment checks.
REQ-032 Sub-module riscv_load_align SHALL implement lane select and extension (REQ-027), and is purely combinational.

Verification
REQ-033 Store byte at addr 0x103, data 0xAB, XLEN=32, req_ready=1 -> req_be=4'b1000, req_wdata=0xABABABAB, req_addr=0x100, stall high 2 cycles.
REQ-034 Load half, signed, at addr 0x202, rsp_rdata=0x8001_1234 -> data_rd_data=0xFFFF8001 in DONE; with mem_unsigned=1 -> 0x00008001.
REQ-035 Load word at addr 0x201 -> err pulses 1 cycle, req_valid never asserts, data_rd_data=0.
REQ-036 TIMEOUT=4, read with rsp_valid held low -> ERR after 4 WAIT_RSP cycles, err=1, then IDLE.
REQ-037 rst=0 while in REQ with req_ready=0 -> req_valid=0 next cycle; rsp_valid pulse afterwards leaves data_rd_data=0.
REQ-038 XLEN=64, dword load at 0x1008, rsp_rdata=0x0123456789ABCDEF -> data_rd_data equals it; mem_size=3 with XLEN=32 -> err.
